// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode bus for instr_fetch_unit: redirect, program-load and the
// {pc, instruction} valid/ready output slot. The master modport is the fetch unit.
interface instr_fetch_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              load_en;
    logic [IDX_W-1:0]  load_addr;
    logic [DATA_W-1:0] load_data;
    logic              inst_ready;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] inst_out;
    logic              fault;

    modport master (
        input  redirect_valid, redirect_pc, load_en, load_addr, load_data, inst_ready,
        output inst_valid, pc_out, inst_out, fault
    );

    modport slave (
        output redirect_valid, redirect_pc, load_en, load_addr, load_data, inst_ready,
        input  inst_valid, pc_out, inst_out, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: word-addressed instruction memory, fetch PC with redirect,
// valid/ready output slot. Optional fetch-fault detection under macro IFU_FAULT_EN.
module instr_fetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                 clock,
    input logic                 reset,
    instr_fetch_unit_if.master  bus
);
    localparam int                IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] inst_q;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              frozen_q, frozen_d;
    logic              slot_free_s;
    logic              fetch_s;
    logic              nop_s;
    logic              bad_pc_s;
    logic [IDX_W-1:0]  idx_s;

    assign idx_s       = fetch_pc_q[IDX_W+1:2];
    assign slot_free_s = !valid_q || bus.inst_ready;

`ifdef IFU_FAULT_EN
    assign bad_pc_s = (fetch_pc_q[1:0] != 2'b00) || ((fetch_pc_q >> 2) >= ADDR_W'(DEPTH));
`else
    assign bad_pc_s = 1'b0;
`endif

    // Program-load write port; the array is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (bus.load_en) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    // Next-state selection in priority order: redirect, load, stall, fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        frozen_d   = frozen_q;
        fetch_s    = 1'b0;
        nop_s      = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            valid_d    = 1'b0;
            fault_d    = 1'b0;
            frozen_d   = 1'b0;
        end else if (bus.load_en) begin
            if (slot_free_s) begin
                valid_d = 1'b0;
                fault_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end else if (!slot_free_s) begin
            valid_d = valid_q;
        end else if (frozen_q) begin
            // A faulted stream waits for a redirect; the accepted slot empties.
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (bad_pc_s) begin
            valid_d  = 1'b1;
            pc_out_d = fetch_pc_q;
            fault_d  = 1'b1;
            frozen_d = 1'b1;
            nop_s    = 1'b1;
        end else begin
            valid_d    = 1'b1;
            pc_out_d   = fetch_pc_q;
            fault_d    = 1'b0;
            fetch_s    = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    // Control and output-slot registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            frozen_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            frozen_q   <= frozen_d;
        end
    end

    // Synchronous memory read into the instruction slot; a faulting fetch presents a NOP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_q <= '0;
        end else if (fetch_s) begin
            inst_q <= mem_q[idx_s];
        end else if (nop_s) begin
            inst_q <= '0;
        end
    end

    assign bus.inst_valid = valid_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.inst_out   = inst_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected slot contents are queued per cycle
// and compared one edge later.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        f;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    instr_fetch_unit_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(8)) ifc ();

    instr_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RESET_PC(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_slot(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic f);
        exp_t e;
        e.v = v; e.pc = pc; e.inst = inst; e.f = f;
        sb.push_back(e);
    endtask

    // One clock edge, then compare the slot against the oldest queued expectation.
    task automatic cycle(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, {31'd0, ifc.inst_valid}, {31'd0, e.v});
            check({tag, "_fault"}, {31'd0, ifc.fault}, {31'd0, e.f});
            if (e.v) begin
                check({tag, "_pc"}, ifc.pc_out, e.pc);
                check({tag, "_inst"}, ifc.inst_out, e.inst);
            end
        end
    endtask

    initial begin
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        ifc.load_en        = 1'b0;
        ifc.load_addr      = 8'h0;
        ifc.load_data      = 32'h0;
        ifc.inst_ready     = 1'b0;

        // Program load while held in reset.
        for (int i = 0; i < 24; i++) begin
            ifc.load_en   = 1'b1;
            ifc.load_addr = 8'(i);
            ifc.load_data = (i < 4) ? (32'h11111111 * 32'(i + 1)) : (32'hA0000000 + 32'(i));
            @(posedge clock);
            #1;
        end
        ifc.load_addr = 8'd255;
        ifc.load_data = 32'hFFFF00FF;
        @(posedge clock);
        #1;
        ifc.load_en = 1'b0;

        check("rst_valid", {31'd0, ifc.inst_valid}, 32'd0);
        check("rst_pc", ifc.pc_out, 32'h0);
        check("rst_inst", ifc.inst_out, 32'h0);
        check("rst_fault", {31'd0, ifc.fault}, 32'd0);

        // Streaming from RESET_PC.
        reset = 1'b0;
        ifc.inst_ready = 1'b1;
        expect_slot(1'b1, 32'h0, 32'h11111111, 1'b0); cycle("t1_0");
        expect_slot(1'b1, 32'h4, 32'h22222222, 1'b0); cycle("t1_4");
        expect_slot(1'b1, 32'h8, 32'h33333333, 1'b0); cycle("t1_8");

        // Backpressure holds the slot.
        ifc.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_slot(1'b1, 32'h8, 32'h33333333, 1'b0);
            cycle("t2_hold");
        end
        ifc.inst_ready = 1'b1;
        expect_slot(1'b1, 32'hC, 32'h44444444, 1'b0); cycle("t2_c");

        // Redirect flushes an unaccepted slot.
        ifc.inst_ready     = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h40;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t3_bubble");
        ifc.redirect_valid = 1'b0;
        ifc.inst_ready     = 1'b1;
        expect_slot(1'b1, 32'h40, 32'hA0000010, 1'b0); cycle("t3_40");
        expect_slot(1'b1, 32'h44, 32'hA0000011, 1'b0); cycle("t3_44");

        // Load mid-stream suppresses fetch.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hC;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t4_redir");
        ifc.redirect_valid = 1'b0;
        ifc.load_en   = 1'b1;
        ifc.load_addr = 8'd3;
        ifc.load_data = 32'hDEADBEEF;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t4_load");
        ifc.load_en = 1'b0;
        expect_slot(1'b1, 32'hC, 32'hDEADBEEF, 1'b0); cycle("t4_c");
        expect_slot(1'b1, 32'h10, 32'hA0000004, 1'b0); cycle("t4_10");
        // Load against a stalled slot leaves it intact.
        ifc.inst_ready = 1'b0;
        ifc.load_en    = 1'b1;
        ifc.load_addr  = 8'd20;
        ifc.load_data  = 32'h12345678;
        expect_slot(1'b1, 32'h10, 32'hA0000004, 1'b0); cycle("t4_ldhold");
        ifc.load_en    = 1'b0;
        ifc.inst_ready = 1'b1;
        expect_slot(1'b1, 32'h14, 32'hA0000005, 1'b0); cycle("t4_14");

        // Top of memory.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h3FC;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t5_redir");
        ifc.redirect_valid = 1'b0;
        expect_slot(1'b1, 32'h3FC, 32'hFFFF00FF, 1'b0); cycle("t5_3fc");
`ifdef IFU_FAULT_EN
        expect_slot(1'b1, 32'h400, 32'h0, 1'b1); cycle("t5_fault");
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t5_frozen0");
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t5_frozen1");
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t5_resume");
        ifc.redirect_valid = 1'b0;
        expect_slot(1'b1, 32'h0, 32'h11111111, 1'b0); cycle("t5_0");
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h2;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t5_redir2");
        ifc.redirect_valid = 1'b0;
        expect_slot(1'b1, 32'h2, 32'h0, 1'b1); cycle("t5_mis");
`else
        expect_slot(1'b1, 32'h400, 32'h11111111, 1'b0); cycle("t5_wrap");
        expect_slot(1'b1, 32'h404, 32'h22222222, 1'b0); cycle("t5_404");
`endif

        // Asynchronous reset mid-stream.
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0;
        expect_slot(1'b0, 32'h0, 32'h0, 1'b0); cycle("t6_redir");
        ifc.redirect_valid = 1'b0;
        expect_slot(1'b1, 32'h0, 32'h11111111, 1'b0); cycle("t6_0");
        expect_slot(1'b1, 32'h4, 32'h22222222, 1'b0); cycle("t6_4");
        #2;
        reset = 1'b1;
        #1;
        check("t6_arst_valid", {31'd0, ifc.inst_valid}, 32'd0);
        check("t6_arst_pc", ifc.pc_out, 32'h0);
        check("t6_arst_inst", ifc.inst_out, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        expect_slot(1'b1, 32'h0, 32'h11111111, 1'b0); cycle("t6_r0");
        expect_slot(1'b1, 32'h4, 32'h22222222, 1'b0); cycle("t6_r4");
        expect_slot(1'b1, 32'h8, 32'h33333333, 1'b0); cycle("t6_r8");
        expect_slot(1'b1, 32'hC, 32'hDEADBEEF, 1'b0); cycle("t6_rc");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
